// File: rtl/seq_divider32.sv
// seq_divider32: multi-cycle restoring integer divider, one quotient bit per clock.
// Companion to the ALU32 shift-add multiplier; shares its clock and reset.
// Optional build macro SIGNED_DIV_EN: two's-complement operands, with an extra
// FIX state that restores the result signs (truncation toward zero).
module seq_divider32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

`ifdef SIGNED_DIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, FIX = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             divZero_q, divZero_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    // The partial remainder is kept WIDTH bits wide: after each restoring step it
    // is strictly below the divisor, so only the shifted intermediate needs the
    // extra bit for the compare.
    logic [WIDTH:0]   shiftedRem;
    logic             canSub;
    logic [WIDTH-1:0] stepRem;
    logic [WIDTH-1:0] stepQuo;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;
    logic [WIDTH-1:0] zeroRem;

    assign shiftedRem = {rem_q, quo_q[WIDTH-1]};
    assign canSub     = (shiftedRem >= {1'b0, div_q});
    assign stepRem    = canSub ? (shiftedRem[WIDTH-1:0] - div_q) : shiftedRem[WIDTH-1:0];
    assign stepQuo    = {quo_q[WIDTH-2:0], canSub};

`ifdef SIGNED_DIV_EN
    logic [WIDTH-1:0] aRaw_q, aRaw_d;
    logic             negQuo_q, negQuo_d;
    logic             negRem_q, negRem_d;

    // Operands are divided as magnitudes; the most-negative value maps onto itself,
    // which read as unsigned is exactly its magnitude.
    assign magA    = a[WIDTH-1] ? -a : a;
    assign magB    = b[WIDTH-1] ? -b : b;
    assign zeroRem = aRaw_q;
`else
    assign magA    = a;
    assign magB    = b;
    // With no steps taken yet the working quotient still holds the dividend.
    assign zeroRem = quo_q;
`endif

    // Next-state and datapath decode for the IDLE/RUN/DONE(/FIX) sequence.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        count_d     = count_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        divZero_d   = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef SIGNED_DIV_EN
        aRaw_d      = aRaw_q;
        negQuo_d    = negQuo_q;
        negRem_d    = negRem_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    rem_d   = '0;
                    quo_d   = magA;
                    div_d   = magB;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
`ifdef SIGNED_DIV_EN
                    aRaw_d   = a;
                    negQuo_d = a[WIDTH-1] ^ b[WIDTH-1];
                    negRem_d = a[WIDTH-1];
`endif
                end
            end
            RUN: begin
                if (div_q == '0) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    divZero_d   = 1'b1;
                    quotient_d  = '1;
                    remainder_d = zeroRem;
                end else begin
                    rem_d   = stepRem;
                    quo_d   = stepQuo;
                    count_d = count_q + CW'(1);
                    if (count_q == LAST_STEP) begin
`ifdef SIGNED_DIV_EN
                        state_d = FIX;
`else
                        state_d     = DONE;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        quotient_d  = stepQuo;
                        remainder_d = stepRem;
`endif
                    end
                end
            end
`ifdef SIGNED_DIV_EN
            FIX: begin
                state_d     = DONE;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                quotient_d  = negQuo_q ? -quo_q : quo_q;
                remainder_d = negRem_q ? -rem_q : rem_q;
            end
`endif
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and working registers; reset aborts any division in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            divZero_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef SIGNED_DIV_EN
            aRaw_q      <= '0;
            negQuo_q    <= 1'b0;
            negRem_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            divZero_q   <= divZero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
`ifdef SIGNED_DIV_EN
            aRaw_q      <= aRaw_d;
            negQuo_q    <= negQuo_d;
            negRem_q    <= negRem_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = divZero_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_seq_divider32.sv
// tb_seq_divider32: self-checking bench for seq_divider32 against a plain
// arithmetic reference model (unsigned, or signed when SIGNED_DIV_EN is set).
module tb_seq_divider32;

    localparam int W = 32;
`ifdef SIGNED_DIV_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int checks = 0;
    int errors = 0;

    seq_divider32 #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_zero(div_zero)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference results straight from the arithmetic definition of division.
    function automatic void refModel(input logic [W-1:0] x, input logic [W-1:0] y,
                                     output logic [W-1:0] q, output logic [W-1:0] r,
                                     output logic dz);
        logic signed [W-1:0] sx;
        logic signed [W-1:0] sy;
        sx = x;
        sy = y;
        dz = (y == '0);
        if (y == '0) begin
            q = '1;
            r = x;
        end else begin
`ifdef SIGNED_DIV_EN
            if (x == MIN_NEG && y == '1) begin
                q = MIN_NEG;
                r = '0;
            end else begin
                q = sx / sy;
                r = sx % sy;
            end
`else
            q = x / y;
            r = x % y;
            if (sx == sy) r = x % y;
`endif
        end
    endfunction

    // Present operands with a one-cycle start pulse; returns at the negedge after acceptance.
    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done, counting negedges on which busy was high.
    task automatic waitDone(output int busyCycles, output bit timedOut);
        int n;
        busyCycles = 0;
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            if (busy === 1'b1) busyCycles++;
            @(negedge clk);
            n++;
        end
        timedOut = (done !== 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, div_zero} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, div_zero});
        end
        checks++;
        if (quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("[TB] FAIL reset_results: got q=%h r=%h expected 0/0", quotient, remainder);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0] xs [3] = '{32'd250, 32'd1000, 32'hFFFFFFFF};
        logic [W-1:0] ys [3] = '{32'd251, 32'd7, 32'd1};
        logic [W-1:0] qs [3] = '{32'd0, 32'd142, 32'hFFFFFFFF};
        logic [W-1:0] rs [3] = '{32'd250, 32'd6, 32'd0};
        int  bc;
        bit  to;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(xs[i], ys[i]);
            waitDone(bc, to);
            checks++;
            if (to) begin
                errors++;
                $display("[TB] FAIL basic_timeout[%0d]: got no done expected done", i);
            end
            checks++;
            if (bc !== LAT) begin
                errors++;
                $display("[TB] FAIL basic_busy_cycles[%0d]: got %0d expected %0d", i, bc, LAT);
            end
            checks++;
            if (quotient !== qs[i] || remainder !== rs[i] || div_zero !== 1'b0) begin
                errors++;
                $display("[TB] FAIL basic_result[%0d]: got q=%h r=%h dz=%b expected q=%h r=%h dz=0",
                         i, quotient, remainder, div_zero, qs[i], rs[i]);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || quotient !== qs[i] || remainder !== rs[i]) begin
                errors++;
                $display("[TB] FAIL basic_done_pulse[%0d]: got done=%b q=%h r=%h expected done=0 q=%h r=%h",
                         i, done, quotient, remainder, qs[i], rs[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int bc;
        bit to;
        applyStimulus(32'd250, 32'd0);
        waitDone(bc, to);
        checks++;
        if (to || bc !== 1) begin
            errors++;
            $display("[TB] FAIL divzero_latency: got busy=%0d timeout=%0d expected busy=1 timeout=0", bc, to);
        end
        checks++;
        if (div_zero !== 1'b1 || quotient !== 32'hFFFFFFFF || remainder !== 32'd250) begin
            errors++;
            $display("[TB] FAIL divzero_result: got dz=%b q=%h r=%h expected dz=1 q=ffffffff r=000000fa",
                     div_zero, quotient, remainder);
        end
        @(negedge clk);
        checks++;
        if (div_zero !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL divzero_clear: got dz=%b done=%b expected 0/0", div_zero, done);
        end
    endtask

    task automatic test_start_while_busy();
        int bc;
        bit to;
        applyStimulus(32'd250, 32'd200);
        repeat (8) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
        end
        a = 32'd9;
        b = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        waitDone(bc, to);
        checks++;
        if (to || quotient !== 32'd1 || remainder !== 32'd50 || div_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_ignore: got q=%h r=%h dz=%b to=%0d expected q=1 r=50 dz=0 to=0",
                     quotient, remainder, div_zero, to);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_ignore_idle: got busy=%b done=%b expected 0/0", busy, done);
        end
    endtask

    task automatic test_reset_mid_op();
        int bc;
        bit to;
        bit sawDone;
        applyStimulus(32'd250, 32'd200);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, div_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("[TB] FAIL reset_abort: got busy=%b done=%b dz=%b q=%h r=%h expected all 0",
                     busy, done, div_zero, quotient, remainder);
        end
        @(negedge clk);
        reset = 1'b0;
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
        end
        checks++;
        if (sawDone !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_no_done: got activity=%b expected 0", sawDone);
        end
        applyStimulus(32'd200, 32'd251);
        waitDone(bc, to);
        checks++;
        if (to || quotient !== 32'd0 || remainder !== 32'd200) begin
            errors++;
            $display("[TB] FAIL reset_restart: got q=%h r=%h to=%0d expected q=0 r=200 to=0",
                     quotient, remainder, to);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x1, y1, x2, y2, eq, er;
        logic         edz;
        int bc;
        bit to;
        x1 = $urandom;
        y1 = $urandom_range(1, 65535);
        x2 = $urandom;
        y2 = $urandom_range(1, 1000);
        applyStimulus(x1, y1);
        waitDone(bc, to);
        refModel(x1, y1, eq, er, edz);
        checks++;
        if (to || quotient !== eq || remainder !== er) begin
            errors++;
            $display("[TB] FAIL b2b_first: got q=%h r=%h expected q=%h r=%h", quotient, remainder, eq, er);
        end
        a = x2;
        b = y2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_accept: got done=%b busy=%b expected done=0 busy=1", done, busy);
        end
        waitDone(bc, to);
        refModel(x2, y2, eq, er, edz);
        checks++;
        if (to || bc !== LAT || quotient !== eq || remainder !== er) begin
            errors++;
            $display("[TB] FAIL b2b_second: got q=%h r=%h busy=%0d expected q=%h r=%h busy=%0d",
                     quotient, remainder, bc, eq, er, LAT);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x, y, eq, er;
        logic         edz;
        int bc;
        bit to;
        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            case (i % 4)
                0: y = $urandom;
                1: y = $urandom_range(1, 255);
                2: y = (i % 8 == 6) ? '0 : W'($urandom_range(1, 15));
                default: y = x | W'($urandom_range(1, 7));
            endcase
            if (i % 6 == 5) x = '0;
            refModel(x, y, eq, er, edz);
            applyStimulus(x, y);
            waitDone(bc, to);
            checks++;
            if (to || quotient !== eq || remainder !== er || div_zero !== edz || bc !== (edz ? 1 : LAT)) begin
                errors++;
                $display("[TB] FAIL random[%0d] a=%h b=%h: got q=%h r=%h dz=%b busy=%0d expected q=%h r=%h dz=%b busy=%0d",
                         i, x, y, quotient, remainder, div_zero, bc, eq, er, edz, edz ? 1 : LAT);
            end
        end
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed();
        int bc;
        bit to;
        applyStimulus(-32'sd7, 32'd2);
        waitDone(bc, to);
        checks++;
        if (to || bc !== W + 1 || quotient !== -32'sd3 || remainder !== -32'sd1) begin
            errors++;
            $display("[TB] FAIL signed_neg7_2: got q=%h r=%h busy=%0d expected q=fffffffd r=ffffffff busy=%0d",
                     quotient, remainder, bc, W + 1);
        end
        applyStimulus(MIN_NEG, 32'hFFFFFFFF);
        waitDone(bc, to);
        checks++;
        if (to || quotient !== MIN_NEG || remainder !== '0 || div_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL signed_minneg: got q=%h r=%h dz=%b expected q=80000000 r=0 dz=0",
                     quotient, remainder, div_zero);
        end
    endtask
`endif

    // Scenario sequence.
    initial begin
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        test_reset();
        test_basic();
        test_div_zero();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
`ifdef SIGNED_DIV_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
